frame_req_arbiter: RTL and testbench

Parametrised N-channel frame-read request arbiter between frame consumers (VGA scan-out, photo save, future channels) and the single read port of the frame read/write engine. Each channel requests one whole frame from a chosen frame-buffer index. The block grants one channel at a time, in fixed-priority or round-robin order, and computes the SDRAM base address as index × stride. It forwards the req/ack handshake, routes read enables and data for the duration of the frame, and recovers from a stalled transfer with a watchdog. It generalises the fixed two-way VGA/save read mux in the system controller.

---
 rtl/frame_arb_pkg.sv | 18 +
 rtl/frame_req_arbiter_rr_pick.sv | 32 +++
 rtl/frame_req_arbiter.sv | 144 ++++++++++++++
 tb/tb_frame_req_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_arb_pkg.sv
// Shared definitions for the frame read request arbiter: FSM states, arbitration
// modes and frame geometry constants also used by the frame read/write engine setup.
package frame_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int FRAME_WIDTH  = 1920;
    localparam int FRAME_HEIGHT = 1080;
    localparam logic [23:0] DEFAULT_FRAME_STRIDE = 24'd2073600;

endpackage

// File: rtl/frame_req_arbiter_rr_pick.sv
// Combinational winner picker: fixed priority from channel 0, or round-robin
// search starting at start_i and wrapping modulo NUM_CH.
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [PTR_W-1:0]  start_i,
    input  logic              rr_mode_i,
    output logic [PTR_W-1:0]  win_o,
    output logic              valid_o
);

    logic [PTR_W-1:0] cand_s;

    // First asserted request in search order wins
    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        cand_s  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand_s = rr_mode_i ? PTR_W'((int'(start_i) + k) % NUM_CH) : PTR_W'(k);
            if (!valid_o && req_i[cand_s]) begin
                valid_o = 1'b1;
                win_o   = cand_s;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/frame_req_arbiter.sv
// N-channel frame read arbiter: grants one consumer at a time to the frame engine
// read port, computes the frame base address and releases stalled transfers.
module frame_req_arbiter
    import frame_arb_pkg::*;
#(
    parameter int               NUM_CH       = 4,
    parameter int               DATA_W       = 16,
    parameter int               ADDR_W       = 24,
    parameter int               IDX_W        = 2,
    parameter logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'(DEFAULT_FRAME_STRIDE),
    parameter int               ARB_MODE     = ARB_FIXED,
    parameter int               TIMEOUT      = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       ch_req_i,
    input  logic [NUM_CH*IDX_W-1:0] ch_idx_i,
    output logic [NUM_CH-1:0]       ch_ack_o,
    input  logic [NUM_CH-1:0]       ch_en_i,
    output logic [DATA_W-1:0]       ch_data_o,
    output logic [NUM_CH-1:0]       grant_o,
    output logic                    dn_req_o,
    output logic [ADDR_W-1:0]       dn_addr_o,
    input  logic                    dn_ack_i,
    output logic                    dn_en_o,
    input  logic [DATA_W-1:0]       dn_data_i,
    input  logic                    dn_finish_i,
    output logic                    timeout_err_o
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_e        state_q;
    logic [NUM_CH-1:0] grant_q;
    logic [NUM_CH-1:0] ch_ack_q;
    logic              dn_req_q;
    logic [ADDR_W-1:0] dn_addr_q;
    logic              timeout_err_q;
    logic [PTR_W-1:0]  last_w_q;
    logic [PTR_W-1:0]  win_q;
    logic [WD_W-1:0]   wdog_q;

    logic [PTR_W-1:0]  start_s;
    logic [PTR_W-1:0]  pick_win_s;
    logic              pick_valid_s;
    logic [IDX_W-1:0]  idx_sel_s;
    logic [ADDR_W-1:0] addr_s;
    logic              en_sel_s;

    assign start_s = (last_w_q == PTR_W'(NUM_CH - 1)) ? '0 : last_w_q + PTR_W'(1);

    rr_pick #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_pick (
        .req_i     (ch_req_i),
        .start_i   (start_s),
        .rr_mode_i (ARB_MODE == ARB_RR),
        .win_o     (pick_win_s),
        .valid_o   (pick_valid_s)
    );

    // Frame index of the prospective winner and of the enable of the current owner
    always_comb begin
        idx_sel_s = '0;
        en_sel_s  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx_sel_s = (pick_win_s == PTR_W'(i)) ? ch_idx_i[i*IDX_W +: IDX_W] : idx_sel_s;
            en_sel_s  = (win_q == PTR_W'(i)) ? ch_en_i[i] : en_sel_s;
        end
    end

    // Base address wraps at ADDR_W by construction of the same-width product
    assign addr_s = {{(ADDR_W-IDX_W){1'b0}}, idx_sel_s} * FRAME_STRIDE;

    // Arbitration FSM with registered handshake outputs and transfer watchdog
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            ch_ack_q      <= '0;
            dn_req_q      <= 1'b0;
            dn_addr_q     <= '0;
            timeout_err_q <= 1'b0;
            last_w_q      <= PTR_W'(NUM_CH - 1);
            win_q         <= '0;
            wdog_q        <= '0;
        end else begin
            ch_ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    wdog_q <= '0;
                    if (pick_valid_s) begin
                        grant_q   <= NUM_CH'(1) << pick_win_s;
                        dn_addr_q <= addr_s;
                        dn_req_q  <= 1'b1;
                        last_w_q  <= pick_win_s;
                        win_q     <= pick_win_s;
                        state_q   <= ST_REQ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (dn_ack_i) begin
                        ch_ack_q <= grant_q;
                        dn_req_q <= 1'b0;
                        state_q  <= ST_XFER;
                    end else begin
                        state_q <= ST_REQ;
                    end
                end
                ST_XFER: begin
                    // A finish coinciding with expiry is a normal completion
                    if (dn_finish_i) begin
                        grant_q <= '0;
                        state_q <= ST_IDLE;
                    end else if ((TIMEOUT > 0) && (wdog_q == WD_W'(TIMEOUT - 1))) begin
                        grant_q       <= '0;
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                default: begin
                    grant_q  <= '0;
                    dn_req_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign ch_ack_o      = ch_ack_q;
    assign dn_req_o      = dn_req_q;
    assign dn_addr_o     = dn_addr_q;
    assign timeout_err_o = timeout_err_q;
    assign dn_en_o       = (state_q == ST_XFER) ? en_sel_s : 1'b0;
    assign ch_data_o     = dn_data_i;

endmodule

// File: tb/tb_frame_req_arbiter.sv
// Directed bench: one fixed-priority instance (no watchdog) and one round-robin
// instance with TIMEOUT=16, driven from shared stimulus.
module tb_frame_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ch_req;
    logic [7:0]  ch_idx;
    logic [3:0]  ch_en;
    logic        dn_ack;
    logic [15:0] dn_data;
    logic        dn_finish;

    logic [3:0]  f_ch_ack, f_grant;
    logic [15:0] f_ch_data;
    logic        f_dn_req, f_dn_en, f_terr;
    logic [23:0] f_dn_addr;

    logic [3:0]  r_ch_ack, r_grant;
    logic [15:0] r_ch_data;
    logic        r_dn_req, r_dn_en, r_terr;
    logic [23:0] r_dn_addr;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    frame_req_arbiter #(.ARB_MODE(0), .TIMEOUT(0)) u_fix (
        .clk_i(clk), .rst_i(rst), .ch_req_i(ch_req), .ch_idx_i(ch_idx),
        .ch_ack_o(f_ch_ack), .ch_en_i(ch_en), .ch_data_o(f_ch_data),
        .grant_o(f_grant), .dn_req_o(f_dn_req), .dn_addr_o(f_dn_addr),
        .dn_ack_i(dn_ack), .dn_en_o(f_dn_en), .dn_data_i(dn_data),
        .dn_finish_i(dn_finish), .timeout_err_o(f_terr)
    );

    frame_req_arbiter #(.ARB_MODE(1), .TIMEOUT(16)) u_rr (
        .clk_i(clk), .rst_i(rst), .ch_req_i(ch_req), .ch_idx_i(ch_idx),
        .ch_ack_o(r_ch_ack), .ch_en_i(ch_en), .ch_data_o(r_ch_data),
        .grant_o(r_grant), .dn_req_o(r_dn_req), .dn_addr_o(r_dn_addr),
        .dn_ack_i(dn_ack), .dn_en_o(r_dn_en), .dn_data_i(dn_data),
        .dn_finish_i(dn_finish), .timeout_err_o(r_terr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_g;
        int rr_order[5] = '{0, 1, 2, 3, 0};

        rst = 1'b1; ch_req = '0; ch_idx = '0; ch_en = '0;
        dn_ack = 1'b0; dn_data = '0; dn_finish = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_f_grant", f_grant, 4'b0000);
        chk("rst_f_dn_req", f_dn_req, 1'b0);
        chk("rst_f_dn_addr", f_dn_addr, 24'd0);
        chk("rst_f_ch_ack", f_ch_ack, 4'b0000);
        chk("rst_f_dn_en", f_dn_en, 1'b0);
        chk("rst_r_terr", r_terr, 1'b0);
        chk("rst_r_grant", r_grant, 4'b0000);

        // Fixed priority: channel 1 wins over 3, index 2
        ch_idx = 8'b0000_1000;
        ch_req = 4'b1010;
        tick();
        chk("fix_grant", f_grant, 4'b0010);
        chk("fix_dn_req", f_dn_req, 1'b1);
        chk("fix_dn_addr", f_dn_addr, 24'd4147200);
        chk("fix_ack_before", f_ch_ack, 4'b0000);
        dn_ack = 1'b1;
        tick();
        chk("fix_ch_ack", f_ch_ack, 4'b0010);
        chk("fix_dn_req_drop", f_dn_req, 1'b0);
        dn_ack = 1'b0;
        ch_req = 4'b0000;
        tick();
        chk("fix_ch_ack_single", f_ch_ack, 4'b0000);
        chk("fix_grant_xfer", f_grant, 4'b0010);
        dn_finish = 1'b1;
        tick();
        dn_finish = 1'b0;
        chk("fix_release", f_grant, 4'b0000);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Round-robin with all channels requesting
        ch_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << rr_order[i];
            tick();
            chk("rr_grant", r_grant, exp_g);
            chk("rr_dn_req", r_dn_req, 1'b1);
            chk("fixall_grant", f_grant, 4'b0001);
            dn_ack = 1'b1;
            tick();
            dn_ack = 1'b0;
            chk("rr_ch_ack", r_ch_ack, exp_g);
            dn_finish = 1'b1;
            tick();
            dn_finish = 1'b0;
            chk("rr_idle_gap", r_grant, 4'b0000);
        end

        // Enable and data routing on channel 2
        ch_req = 4'b0100;
        ch_idx = 8'b0001_0000;
        tick();
        chk("ch2_grant", r_grant, 4'b0100);
        chk("ch2_dn_addr", r_dn_addr, 24'd2073600);
        dn_ack = 1'b1;
        tick();
        dn_ack = 1'b0;
        ch_req = 4'b0000;
        ch_en = 4'b0001;
        dn_data = 16'hA5A5;
        #1;
        chk("en_other_only", r_dn_en, 1'b0);
        chk("ch_data_pass", r_ch_data, 16'hA5A5);
        ch_en = 4'b0100;
        #1;
        chk("en_own", r_dn_en, 1'b1);
        chk("en_own_fix", f_dn_en, 1'b1);
        ch_en = 4'b0101;
        dn_data = 16'h5A3C;
        #1;
        chk("en_both", r_dn_en, 1'b1);
        chk("ch_data_pass2", f_ch_data, 16'h5A3C);
        ch_en = 4'b0000;
        #1;
        chk("en_none", r_dn_en, 1'b0);
        dn_finish = 1'b1;
        tick();
        dn_finish = 1'b0;

        // Watchdog expiry with no finish
        ch_req = 4'b0001;
        tick();
        chk("wd_grant", r_grant, 4'b0001);
        dn_ack = 1'b1;
        tick();
        dn_ack = 1'b0;
        ch_req = 4'b0000;
        repeat (15) tick();
        chk("wd_cycle16_held", r_grant, 4'b0001);
        chk("wd_cycle16_noerr", r_terr, 1'b0);
        tick();
        chk("wd_release", r_grant, 4'b0000);
        chk("wd_terr_set", r_terr, 1'b1);
        chk("wd_disabled", f_grant, 4'b0001);
        repeat (3) tick();
        chk("wd_terr_sticky", r_terr, 1'b1);
        dn_finish = 1'b1;
        tick();
        dn_finish = 1'b0;
        ch_req = 4'b1000;
        ch_idx = 8'b0100_0000;
        tick();
        chk("wd_next_grant", r_grant, 4'b1000);
        chk("wd_next_addr", r_dn_addr, 24'd2073600);
        chk("wd_terr_kept", r_terr, 1'b1);
        dn_ack = 1'b1;
        tick();
        dn_ack = 1'b0;
        ch_req = 4'b0000;
        dn_finish = 1'b1;
        tick();
        dn_finish = 1'b0;

        // Finish exactly at the expiry cycle counts as normal completion
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("fin16_terr_clear", r_terr, 1'b0);
        ch_req = 4'b0001;
        tick();
        dn_ack = 1'b1;
        tick();
        dn_ack = 1'b0;
        ch_req = 4'b0000;
        repeat (15) tick();
        chk("fin16_held", r_grant, 4'b0001);
        dn_finish = 1'b1;
        tick();
        dn_finish = 1'b0;
        chk("fin16_release", r_grant, 4'b0000);
        chk("fin16_no_err", r_terr, 1'b0);

        // Reset in the middle of a transfer
        ch_req = 4'b0100;
        tick();
        chk("rstx_grant", r_grant, 4'b0100);
        dn_ack = 1'b1;
        tick();
        dn_ack = 1'b0;
        ch_req = 4'b0000;
        ch_en = 4'b0100;
        #1;
        chk("rstx_en_before", r_dn_en, 1'b1);
        rst = 1'b1;
        tick();
        chk("rstx_grant0", r_grant, 4'b0000);
        chk("rstx_en0", r_dn_en, 1'b0);
        chk("rstx_req0", r_dn_req, 1'b0);
        chk("rstx_f_en0", f_dn_en, 1'b0);
        rst = 1'b0;
        ch_en = 4'b0000;
        ch_req = 4'b1000;
        ch_idx = 8'b1100_0000;
        tick();
        chk("rstx_ch3_grant", r_grant, 4'b1000);
        chk("rstx_ch3_addr", r_dn_addr, 24'd6220800);
        chk("rstx_ch3_req", r_dn_req, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
